// File: rtl/param_bank.sv
// Double-buffered, multi-channel parameter bank: host writes shadow tables,
// per-channel commits copy shadow to active only at a waveform cycle boundary.
module param_bank #(
   parameter  int PARAM_SIZE = 32,
   parameter  int POINTS     = 9,
   parameter  int CHANNELS   = 2,
   localparam int OFS_W      = $clog2(3*POINTS+2),
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int ADDR_W     = CH_W + OFS_W
) (
   input  logic                                 aclk,
   input  logic                                 aresetn,
   input  logic                                 wr_en,
   input  logic [ADDR_W-1:0]                    wr_addr,
   input  logic [PARAM_SIZE-1:0]                wr_data,
   output logic                                 wr_ack,
   output logic                                 wr_err,
   input  logic [CHANNELS-1:0]                  commit_req,
   input  logic [CHANNELS-1:0]                  gen_run,
   input  logic [CHANNELS-1:0]                  cycle_end,
   output logic [CHANNELS-1:0]                  commit_pending,
   output logic [CHANNELS-1:0]                  commit_done,
   output logic [CHANNELS-1:0]                  commit_err,
   output logic [CHANNELS*POINTS*PARAM_SIZE-1:0] act_linea,
   output logic [CHANNELS*POINTS*PARAM_SIZE-1:0] act_linet,
   output logic [CHANNELS*POINTS*PARAM_SIZE-1:0] act_linet_int,
   output logic [CHANNELS*PARAM_SIZE-1:0]       act_linenmb,
   output logic [CHANNELS*PARAM_SIZE-1:0]       act_repeatcycle
);

   localparam int NWORDS  = 3*POINTS + 2;
   localparam int OFS_NMB = 3*POINTS;
   localparam int OFS_REP = 3*POINTS + 1;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PENDING = 1'b1;

   logic [PARAM_SIZE-1:0] shadow_q [CHANNELS][NWORDS];
   logic [PARAM_SIZE-1:0] active_q [CHANNELS][NWORDS];
   logic [0:0]            state_q  [CHANNELS];
   logic [0:0]            state_d  [CHANNELS];

   logic [CH_W-1:0]       wrCh;
   logic [OFS_W-1:0]      wrOfs;
   logic                  wrOfsOk;
   logic [CHANNELS-1:0]   wrSel;
   logic                  wrAck_d, wrErr_d;
   logic                  wrAck_q, wrErr_q;
   logic [CHANNELS-1:0]   applyCh;
   logic [CHANNELS-1:0]   commitDone_d, commitErr_d;
   logic [CHANNELS-1:0]   commitDone_q, commitErr_q;

   assign wrCh    = wr_addr[ADDR_W-1:OFS_W];
   assign wrOfs   = wr_addr[OFS_W-1:0];
   assign wrOfsOk = ({{(32-OFS_W){1'b0}}, wrOfs} < 32'(NWORDS));

   // A write lands only on an existing channel that is not waiting for a boundary;
   // a channel index beyond CHANNELS simply matches no select line.
   always_comb begin
      wrSel = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         wrSel[c] = wr_en && wrOfsOk && (wrCh == CH_W'(c)) && (state_q[c] == ST_IDLE);
      end
      wrAck_d = |wrSel;
      wrErr_d = wr_en && !(|wrSel);
   end

   // Commit FSM per channel; a boundary seen in IDLE is never consumed by a new request.
   always_comb begin
      applyCh      = '0;
      commitDone_d = '0;
      commitErr_d  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         state_d[c] = state_q[c];
         case (state_q[c])
            ST_IDLE: begin
               if (commit_req[c]) begin
                  if ((shadow_q[c][OFS_NMB] != '0) &&
                      (shadow_q[c][OFS_NMB] <= PARAM_SIZE'(POINTS))) begin
                     state_d[c] = ST_PENDING;
                  end else begin
                     commitErr_d[c] = 1'b1;
                  end
               end
            end
            default: begin
               if (cycle_end[c] || !gen_run[c]) begin
                  applyCh[c]      = 1'b1;
                  commitDone_d[c] = 1'b1;
                  state_d[c]      = ST_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int c = 0; c < CHANNELS; c++) begin
            state_q[c] <= ST_IDLE;
            for (int w = 0; w < NWORDS; w++) begin
               shadow_q[c][w] <= '0;
               active_q[c][w] <= '0;
            end
         end
         wrAck_q      <= 1'b0;
         wrErr_q      <= 1'b0;
         commitDone_q <= '0;
         commitErr_q  <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            state_q[c] <= state_d[c];
            if (wrSel[c]) begin
               shadow_q[c][wrOfs] <= wr_data;
            end
            if (applyCh[c]) begin
               for (int w = 0; w < NWORDS; w++) begin
                  active_q[c][w] <= shadow_q[c][w];
               end
            end
         end
         wrAck_q      <= wrAck_d;
         wrErr_q      <= wrErr_d;
         commitDone_q <= commitDone_d;
         commitErr_q  <= commitErr_d;
      end
   end

   assign wr_ack      = wrAck_q;
   assign wr_err      = wrErr_q;
   assign commit_done = commitDone_q;
   assign commit_err  = commitErr_q;

   // Flatten active tables channel-major, point-minor.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign commit_pending[c] = (state_q[c] == ST_PENDING);
      assign act_linenmb[c*PARAM_SIZE +: PARAM_SIZE]     = active_q[c][OFS_NMB];
      assign act_repeatcycle[c*PARAM_SIZE +: PARAM_SIZE] = active_q[c][OFS_REP];
      for (genvar i = 0; i < POINTS; i++) begin : g_pt
         assign act_linea[(c*POINTS+i)*PARAM_SIZE +: PARAM_SIZE]     = active_q[c][i];
         assign act_linet[(c*POINTS+i)*PARAM_SIZE +: PARAM_SIZE]     = active_q[c][POINTS+i];
         assign act_linet_int[(c*POINTS+i)*PARAM_SIZE +: PARAM_SIZE] = active_q[c][2*POINTS+i];
      end
   end

endmodule

// File: tb/tb_param_bank.sv
// Directed self-checking bench for param_bank with three channels so that an
// out-of-range channel index is representable on the address bus.
module tb_param_bank;

   localparam int W   = 32;
   localparam int P   = 9;
   localparam int CH  = 3;
   localparam int AW  = 7;
   localparam int NMB = 3*P;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [W-1:0]      wr_data;
   logic              wr_ack, wr_err;
   logic [CH-1:0]     commit_req, gen_run, cycle_end;
   logic [CH-1:0]     commit_pending, commit_done, commit_err;
   logic [CH*P*W-1:0] act_linea, act_linet, act_linet_int;
   logic [CH*W-1:0]   act_linenmb, act_repeatcycle;

   int checkCount = 0;
   int passCount  = 0;

   param_bank #(.PARAM_SIZE(W), .POINTS(P), .CHANNELS(CH)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .wr_err(wr_err),
      .commit_req(commit_req), .gen_run(gen_run), .cycle_end(cycle_end),
      .commit_pending(commit_pending), .commit_done(commit_done), .commit_err(commit_err),
      .act_linea(act_linea), .act_linet(act_linet), .act_linet_int(act_linet_int),
      .act_linenmb(act_linenmb), .act_repeatcycle(act_repeatcycle)
   );

   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic doWrite(input logic [1:0] ch, input logic [4:0] ofs, input logic [W-1:0] data);
      wr_en   = 1'b1;
      wr_addr = {ch, ofs};
      wr_data = data;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic pulseCommit(input int ch);
      commit_req[ch] = 1'b1;
      tick();
      commit_req = '0;
   endtask

   task automatic test_reset();
      aresetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      commit_req = '0; gen_run = '0; cycle_end = '0;
      #23;
      checkCount++;
      if ({act_linea, act_linet, act_linet_int, act_linenmb, act_repeatcycle} !== '0)
         $display("[TB] FAIL reset_active: got nonzero active words, required all 0");
      else passCount++;
      checkCount++;
      if ({wr_ack, wr_err, commit_pending, commit_done, commit_err} !== '0)
         $display("[TB] FAIL reset_status: got %b required 0", {wr_ack, wr_err, commit_pending, commit_done, commit_err});
      else passCount++;
      aresetn = 1'b1;
      tick();
   endtask

   task automatic test_commit_idle();
      doWrite(2'd0, 5'(NMB), 32'd3);
      checkCount++;
      if ({wr_ack, wr_err} !== 2'b10) $display("[TB] FAIL write_ack: got %b required 10", {wr_ack, wr_err});
      else passCount++;
      doWrite(2'd0, 5'd0, 32'h100);
      gen_run[0] = 1'b0;
      pulseCommit(0);
      checkCount++;
      if (commit_pending[0] !== 1'b1 || commit_done[0] !== 1'b0 || act_linenmb[0 +: W] !== 32'd0)
         $display("[TB] FAIL idle_first_edge: got pend=%b done=%b nmb=%0h required 1 0 0",
                  commit_pending[0], commit_done[0], act_linenmb[0 +: W]);
      else passCount++;
      tick();
      checkCount++;
      if (commit_done !== 3'b001 || commit_pending[0] !== 1'b0)
         $display("[TB] FAIL idle_done: got done=%b pend=%b required 001 0", commit_done, commit_pending[0]);
      else passCount++;
      checkCount++;
      if (act_linenmb[0 +: W] !== 32'd3 || act_linea[0 +: W] !== 32'h100)
         $display("[TB] FAIL idle_values: got nmb=%0h linea0=%0h required 3 100", act_linenmb[0 +: W], act_linea[0 +: W]);
      else passCount++;
      checkCount++;
      if (act_linenmb[W +: W] !== 32'd0 || act_linea[P*W +: W] !== 32'd0)
         $display("[TB] FAIL idle_ch1_untouched: got nmb=%0h linea0=%0h required 0 0", act_linenmb[W +: W], act_linea[P*W +: W]);
      else passCount++;
      tick();
      checkCount++;
      if (commit_done !== 3'b000) $display("[TB] FAIL done_one_cycle: got %b required 000", commit_done);
      else passCount++;
   endtask

   task automatic test_pending_boundary();
      bit stayed = 1'b1;
      gen_run[1] = 1'b1;
      doWrite(2'd1, 5'(NMB), 32'd5);
      doWrite(2'd1, 5'(P+2), 32'hABC);
      pulseCommit(1);
      checkCount++;
      if (commit_pending !== 3'b010) $display("[TB] FAIL run_pending: got %b required 010", commit_pending);
      else passCount++;
      doWrite(2'd1, 5'(NMB), 32'd7);
      checkCount++;
      if ({wr_ack, wr_err} !== 2'b01) $display("[TB] FAIL write_while_pending: got %b required 01", {wr_ack, wr_err});
      else passCount++;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (commit_pending[1] !== 1'b1 || commit_done[1] !== 1'b0) stayed = 1'b0;
      end
      checkCount++;
      if (!stayed) $display("[TB] FAIL hold_pending: got dropped/applied early required pending 10 cycles");
      else passCount++;
      checkCount++;
      if (act_linenmb[W +: W] !== 32'd0) $display("[TB] FAIL no_early_apply: got %0h required 0", act_linenmb[W +: W]);
      else passCount++;
      cycle_end[1] = 1'b1;
      tick();
      cycle_end = '0;
      checkCount++;
      if (commit_done !== 3'b010 || commit_pending !== 3'b000)
         $display("[TB] FAIL boundary_done: got done=%b pend=%b required 010 000", commit_done, commit_pending);
      else passCount++;
      checkCount++;
      if (act_linenmb[W +: W] !== 32'd5 || act_linet[(P+2)*W +: W] !== 32'hABC)
         $display("[TB] FAIL boundary_values: got nmb=%0h linet2=%0h required 5 abc", act_linenmb[W +: W], act_linet[(P+2)*W +: W]);
      else passCount++;
      checkCount++;
      if (act_linenmb[0 +: W] !== 32'd3) $display("[TB] FAIL ch0_isolated: got %0h required 3", act_linenmb[0 +: W]);
      else passCount++;
   endtask

   task automatic test_commit_err();
      gen_run[2] = 1'b0;
      pulseCommit(2);
      checkCount++;
      if (commit_err !== 3'b100 || commit_pending[2] !== 1'b0)
         $display("[TB] FAIL err_zero: got err=%b pend=%b required 100 0", commit_err, commit_pending[2]);
      else passCount++;
      doWrite(2'd2, 5'(NMB), 32'(P+1));
      checkCount++;
      if (commit_err !== 3'b000) $display("[TB] FAIL err_one_cycle: got %b required 000", commit_err);
      else passCount++;
      doWrite(2'd2, 5'd0, 32'h55);
      pulseCommit(2);
      checkCount++;
      if (commit_err !== 3'b100 || commit_pending[2] !== 1'b0)
         $display("[TB] FAIL err_over: got err=%b pend=%b required 100 0", commit_err, commit_pending[2]);
      else passCount++;
      tick();
      checkCount++;
      if (commit_done[2] !== 1'b0 || act_linenmb[2*W +: W] !== 32'd0 || act_linea[2*P*W +: W] !== 32'd0)
         $display("[TB] FAIL err_no_apply: got done=%b nmb=%0h linea0=%0h required 0 0 0",
                  commit_done[2], act_linenmb[2*W +: W], act_linea[2*P*W +: W]);
      else passCount++;
      doWrite(2'd2, 5'(NMB), 32'(P));
      pulseCommit(2);
      tick();
      checkCount++;
      if (commit_done[2] !== 1'b1 || act_linenmb[2*W +: W] !== 32'(P) || act_linea[2*P*W +: W] !== 32'h55)
         $display("[TB] FAIL nmb_max_ok: got done=%b nmb=%0h linea0=%0h required 1 9 55",
                  commit_done[2], act_linenmb[2*W +: W], act_linea[2*P*W +: W]);
      else passCount++;
   endtask

   task automatic test_addr_range();
      doWrite(2'd0, 5'(NMB+2), 32'hDEAD);
      checkCount++;
      if ({wr_ack, wr_err} !== 2'b01) $display("[TB] FAIL ofs_range: got %b required 01", {wr_ack, wr_err});
      else passCount++;
      doWrite(2'd3, 5'(NMB), 32'd2);
      checkCount++;
      if ({wr_ack, wr_err} !== 2'b01) $display("[TB] FAIL ch_range: got %b required 01", {wr_ack, wr_err});
      else passCount++;
      pulseCommit(0);
      tick();
      checkCount++;
      if (act_linenmb[0 +: W] !== 32'd3 || act_repeatcycle[0 +: W] !== 32'd0 || act_linea[0 +: W] !== 32'h100)
         $display("[TB] FAIL range_no_change: got nmb=%0h rep=%0h linea0=%0h required 3 0 100",
                  act_linenmb[0 +: W], act_repeatcycle[0 +: W], act_linea[0 +: W]);
      else passCount++;
      doWrite(2'd1, 5'(NMB+1), 32'h44);
      commit_req[1] = 1'b1;
      cycle_end[1]  = 1'b1;
      tick();
      commit_req = '0;
      cycle_end  = '0;
      checkCount++;
      if (commit_pending[1] !== 1'b1 || commit_done[1] !== 1'b0)
         $display("[TB] FAIL same_cycle_pend: got pend=%b done=%b required 1 0", commit_pending[1], commit_done[1]);
      else passCount++;
      tick(); tick();
      checkCount++;
      if (commit_done[1] !== 1'b0 || act_repeatcycle[W +: W] !== 32'd0)
         $display("[TB] FAIL same_cycle_wait: got done=%b rep=%0h required 0 0", commit_done[1], act_repeatcycle[W +: W]);
      else passCount++;
      cycle_end[1] = 1'b1;
      tick();
      cycle_end = '0;
      checkCount++;
      if (commit_done[1] !== 1'b1 || act_repeatcycle[W +: W] !== 32'h44)
         $display("[TB] FAIL same_cycle_apply: got done=%b rep=%0h required 1 44", commit_done[1], act_repeatcycle[W +: W]);
      else passCount++;
   endtask

   task automatic test_reset_pending();
      gen_run[0] = 1'b1;
      doWrite(2'd0, 5'(NMB), 32'd4);
      pulseCommit(0);
      checkCount++;
      if (commit_pending[0] !== 1'b1) $display("[TB] FAIL pre_reset_pend: got %b required 1", commit_pending[0]);
      else passCount++;
      #2 aresetn = 1'b0;
      #1;
      checkCount++;
      if (commit_pending !== 3'b000 || {act_linea, act_linet, act_linet_int, act_linenmb, act_repeatcycle} !== '0)
         $display("[TB] FAIL async_reset: got pend=%b or nonzero active required 000 and all 0", commit_pending);
      else passCount++;
      cycle_end[0] = 1'b1;
      tick();
      cycle_end = '0;
      aresetn = 1'b1;
      tick();
      checkCount++;
      if ({wr_ack, wr_err, commit_pending, commit_done, commit_err} !== '0 || act_linenmb !== '0)
         $display("[TB] FAIL post_reset: got status=%b nmb=%0h required 0 0",
                  {wr_ack, wr_err, commit_pending, commit_done, commit_err}, act_linenmb);
      else passCount++;
      gen_run = '0;
      pulseCommit(0);
      checkCount++;
      if (commit_err[0] !== 1'b1 || commit_pending[0] !== 1'b0)
         $display("[TB] FAIL shadow_cleared: got err=%b pend=%b required 1 0", commit_err[0], commit_pending[0]);
      else passCount++;
   endtask

   initial begin
      test_reset();
      test_commit_idle();
      test_pending_boundary();
      test_commit_err();
      test_addr_range();
      test_reset_pending();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/param_bank.md
# param_bank

Multi-channel, double-buffered parameter register bank for the signal generator. A simple write bus loads shadow copies of the per-channel segment tables: amplitudes, times, integer times, line count and repeat count. A per-channel commit transfers the shadow copy to the active copy atomically, only at a waveform cycle boundary, so a running generator never sees a half-updated table. It sits between the host configurator and the generator channels and replaces the single-channel, unbuffered parameter set.

## Interface
- PARAM_SIZE, 32, width of every parameter word
- POINTS, 9, segment points per channel table
- CHANNELS, 2, number of independent generator channels (>=1)
- Derived: OFS_W = clog2(3*POINTS+2); CH_W = max(1, clog2(CHANNELS)); ADDR_W = CH_W+OFS_W

Ports:
- aclk  in  1  single clock; all logic on its rising edge
- aresetn  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe, one word per cycle
- wr_addr  in  ADDR_W  {channel, offset}
- wr_data  in  PARAM_SIZE  write data
- wr_ack  out  1  registered pulse: write accepted
- wr_err  out  1  registered pulse: write rejected
- commit_req  in  CHANNELS  per-channel commit pulse
- gen_run  in  CHANNELS  channel generator is running
- cycle_end  in  CHANNELS  pulse on the last clock of a waveform repeat cycle
- commit_pending  out  CHANNELS  channel is waiting for a boundary
- commit_done  out  CHANNELS  registered pulse: active copy updated
- commit_err  out  CHANNELS  registered pulse: commit refused (invalid linenmb)
- act_linea, act_linet, act_linet_int  out  CHANNELS*POINTS*PARAM_SIZE  active tables, channel-major, point-minor
- act_linenmb, act_repeatcycle  out  CHANNELS*PARAM_SIZE  active scalars

## Operation
- Offset map per channel:
  - 0..P-1: linea[i]
  - P..2P-1: linet[i]
  - 2P..3P-1: linet_int[i]
  - 3P: linenmb
  - 3P+1: repeatcycle
- Write rejection (wr_err, shadow unchanged) when any of these holds:
  - channel >= CHANNELS
  - offset > 3P+1
  - target channel is PENDING
- Per-channel FSM, IDLE and PENDING:
  - IDLE + commit_req, shadow linenmb in 1..POINTS: go to PENDING.
  - IDLE + commit_req, shadow linenmb outside 1..POINTS: commit_err pulse, stay IDLE.
  - PENDING + (cycle_end or !gen_run): copy the entire shadow to active in one edge, pulse commit_done, go to IDLE.
  - PENDING + commit_req: ignored, no error.
- IDLE with commit_req and cycle_end in the same cycle: cycle_end is not consumed; the commit applies at the next boundary.
- Channels are fully independent; commits on several channels in the same cycle are allowed.
- A write to a channel never changes that channel's active copy.

## Timing
- Reset: every shadow and active word is 0. State is IDLE. wr_ack, wr_err, commit_pending, commit_done and commit_err are all 0.
- Write sampled at edge N: shadow updated at edge N; wr_ack/wr_err high for exactly the cycle after N.
- commit_req at edge N: commit_pending=1 from edge N (or commit_err high for the cycle after N).
- Apply at edge M: act_* hold new values from edge M; commit_done high for one cycle after M; commit_pending drops at M.
- Not running: req at edge N, state PENDING, apply at edge N+1. Commit-to-active latency is 2 edges.
- Reset asserted mid-PENDING: state returns to IDLE and both copies return to 0, with no commit_done.

## Test plan
- Reset then read outputs:
  - all act_* = 0
  - all status outputs 0
- Write ch0 linenmb=3, linea[0]=0x100; commit with gen_run=0:
  - commit_done on the 2nd edge after req
  - act_linenmb[ch0]=3, act_linea[ch0][0]=0x100
  - ch1 unchanged
- gen_run[1]=1, commit ch1 with linenmb=5:
  - stays pending across 10 cycles
  - applies on the cycle_end edge
  - a write to ch1 while pending returns wr_err and leaves the shadow unchanged
- Commit with linenmb=0, then with linenmb=POINTS+1:
  - commit_err both times
  - never pending, active unchanged
- Address out of range: write offset 3P+2 and channel=CHANNELS -> wr_err, no shadow change. Also commit_req with cycle_end in the same IDLE cycle -> applies only at the next cycle_end.
- aresetn pulsed low while ch0 is pending -> no commit_done, all outputs back to reset values.
